// File: rtl/data_mem_pkg.sv
// Shared types and defaults for the data memory arbiter slice.
// Holds the FSM state encoding, requester ids and default geometry.
package data_mem_pkg;

    localparam int DEF_AW    = 16;
    localparam int DEF_DW    = 16;
    localparam int DEF_DEPTH = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// The pointer only breaks ties; a lone requester always wins.
module rr_arb2
    import data_mem_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic ptr,
    output logic grant,
    output logic grant_valid
);

    always_comb begin
        grant_valid = req_a | req_b;
        if (req_a && req_b) begin
            grant = ptr;
        end else if (req_b) begin
            grant = PORT_B;
        end else begin
            grant = PORT_A;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares a single-port data memory between port A (CPU) and port B (loader)
// with round-robin arbitration; one access takes IDLE -> ACCESS -> RESP.
module data_mem_arbiter
    import data_mem_pkg::*;
#(
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          A_Req,
    input  logic          A_We,
    input  logic [AW-1:0] A_Addr,
    input  logic [DW-1:0] A_WData,
    output logic          A_Ack,
    output logic [DW-1:0] A_RData,
    output logic          A_Err,
    input  logic          B_Req,
    input  logic          B_We,
    input  logic [AW-1:0] B_Addr,
    input  logic [DW-1:0] B_WData,
    output logic          B_Ack,
    output logic [DW-1:0] B_RData,
    output logic          B_Err,
    output logic [AW-1:0] Mem_Addr,
    output logic          Mem_Read,
    output logic          Mem_Write,
    output logic [DW-1:0] Mem_Data_In,
    input  logic [DW-1:0] Mem_Data_Out,
    output logic [1:0]    Dbg_State
);

    // Handshake: a port holds Req (with We/Addr/WData stable) until it sees a
    // one-cycle Ack; Req is only sampled in IDLE, so a stale Req during RESP
    // never starts a second access.

    localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);

    state_t        state_q, state_d;
    logic          ptr_q, ptr_d;
    logic          lat_port_q, lat_port_d;
    logic          lat_oor_q, lat_oor_d;

    logic [AW-1:0] mem_addr_d;
    logic          mem_read_d, mem_write_d;
    logic [DW-1:0] mem_din_d;
    logic          a_ack_d, b_ack_d, a_err_d, b_err_d;
    logic [DW-1:0] a_rdata_d, b_rdata_d;

    logic          grant, grant_valid;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_in_range;
    logic [DW-1:0] resp_data;

    rr_arb2 u_arb (
        .req_a       (A_Req),
        .req_b       (B_Req),
        .ptr         (ptr_q),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    assign sel_we       = (grant == PORT_B) ? B_We    : A_We;
    assign sel_addr     = (grant == PORT_B) ? B_Addr  : A_Addr;
    assign sel_wdata    = (grant == PORT_B) ? B_WData : A_WData;
    assign sel_in_range = ({1'b0, sel_addr} < LIMIT);
    assign resp_data    = lat_oor_q ? '0 : Mem_Data_Out;
    assign Dbg_State    = state_q;

    // The Mem_* output registers double as the request latch: they are loaded
    // on the grant edge and hold address/direction/data through ACCESS.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        lat_port_d  = lat_port_q;
        lat_oor_d   = lat_oor_q;
        mem_addr_d  = '0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_din_d   = '0;
        a_ack_d     = 1'b0;
        b_ack_d     = 1'b0;
        a_err_d     = 1'b0;
        b_err_d     = 1'b0;
        a_rdata_d   = A_RData;
        b_rdata_d   = B_RData;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    lat_port_d  = grant;
                    lat_oor_d   = ~sel_in_range;
                    mem_addr_d  = sel_addr;
                    mem_read_d  = sel_in_range & ~sel_we;
                    mem_write_d = sel_in_range & sel_we;
                    mem_din_d   = (sel_in_range && sel_we) ? sel_wdata : '0;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                ptr_d = ~lat_port_q;
                if (lat_port_q == PORT_B) begin
                    b_ack_d   = 1'b1;
                    b_err_d   = lat_oor_q;
                    b_rdata_d = resp_data;
                end else begin
                    a_ack_d   = 1'b1;
                    a_err_d   = lat_oor_q;
                    a_rdata_d = resp_data;
                end
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= IDLE;
            ptr_q       <= PORT_A;
            lat_port_q  <= PORT_A;
            lat_oor_q   <= 1'b0;
            Mem_Addr    <= '0;
            Mem_Read    <= 1'b0;
            Mem_Write   <= 1'b0;
            Mem_Data_In <= '0;
            A_Ack       <= 1'b0;
            A_Err       <= 1'b0;
            A_RData     <= '0;
            B_Ack       <= 1'b0;
            B_Err       <= 1'b0;
            B_RData     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            lat_port_q  <= lat_port_d;
            lat_oor_q   <= lat_oor_d;
            Mem_Addr    <= mem_addr_d;
            Mem_Read    <= mem_read_d;
            Mem_Write   <= mem_write_d;
            Mem_Data_In <= mem_din_d;
            A_Ack       <= a_ack_d;
            A_Err       <= a_err_d;
            A_RData     <= a_rdata_d;
            B_Ack       <= b_ack_d;
            B_Err       <= b_err_d;
            B_RData     <= b_rdata_d;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a negedge-sampled memory model.
module tb_data_mem_arbiter;

    logic        Clk;
    logic        Rst;
    logic        A_Req, A_We, A_Ack, A_Err;
    logic [15:0] A_Addr, A_WData, A_RData;
    logic        B_Req, B_We, B_Ack, B_Err;
    logic [15:0] B_Addr, B_WData, B_RData;
    logic [15:0] Mem_Addr, Mem_Data_In, Mem_Data_Out;
    logic        Mem_Read, Mem_Write;
    logic [1:0]  Dbg_State;

    logic        mem_init;
    logic [15:0] mem [0:63];

    int n_cmp = 0;
    int n_err = 0;
    int a_pulses;

    data_mem_arbiter dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .A_Req        (A_Req),
        .A_We         (A_We),
        .A_Addr       (A_Addr),
        .A_WData      (A_WData),
        .A_Ack        (A_Ack),
        .A_RData      (A_RData),
        .A_Err        (A_Err),
        .B_Req        (B_Req),
        .B_We         (B_We),
        .B_Addr       (B_Addr),
        .B_WData      (B_WData),
        .B_Ack        (B_Ack),
        .B_RData      (B_RData),
        .B_Err        (B_Err),
        .Mem_Addr     (Mem_Addr),
        .Mem_Read     (Mem_Read),
        .Mem_Write    (Mem_Write),
        .Mem_Data_In  (Mem_Data_In),
        .Mem_Data_Out (Mem_Data_Out),
        .Dbg_State    (Dbg_State)
    );

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // memory model: acts on negedge, preloaded word[1]=0x0002, word[3]=0x00AA
    always @(negedge Clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
            mem[1] <= 16'h0002;
            mem[3] <= 16'h00AA;
            Mem_Data_Out <= '0;
        end else if (Mem_Write && Mem_Addr < 16'd64) begin
            mem[Mem_Addr[5:0]] <= Mem_Data_In;
            Mem_Data_Out <= Mem_Data_In;
        end else if (Mem_Read && Mem_Addr < 16'd64) begin
            Mem_Data_Out <= mem[Mem_Addr[5:0]];
        end
    end

    // driver helpers
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_a(input logic req, input logic we, input logic [15:0] addr,
                           input logic [15:0] wdata);
        A_Req = req; A_We = we; A_Addr = addr; A_WData = wdata;
    endtask

    task automatic drive_b(input logic req, input logic we, input logic [15:0] addr,
                           input logic [15:0] wdata);
        B_Req = req; B_We = we; B_Addr = addr; B_WData = wdata;
    endtask

    // scoreboard check
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".A_Ack"},     32'(A_Ack), 0);
        check({tag, ".A_Err"},     32'(A_Err), 0);
        check({tag, ".A_RData"},   32'(A_RData), 0);
        check({tag, ".B_Ack"},     32'(B_Ack), 0);
        check({tag, ".B_Err"},     32'(B_Err), 0);
        check({tag, ".B_RData"},   32'(B_RData), 0);
        check({tag, ".Mem_Addr"},  32'(Mem_Addr), 0);
        check({tag, ".Mem_Read"},  32'(Mem_Read), 0);
        check({tag, ".Mem_Write"}, 32'(Mem_Write), 0);
        check({tag, ".Mem_DIn"},   32'(Mem_Data_In), 0);
        check({tag, ".state"},     32'(Dbg_State), 0);
    endtask

    initial begin
        Rst = 1'b1;
        mem_init = 1'b1;
        drive_a(0, 0, 0, 0);
        drive_b(0, 0, 0, 0);
        tick();
        tick();
        mem_init = 1'b0;
        check_all_zero("reset");

        // 1: A reads word 1
        Rst = 1'b0;
        drive_a(1, 0, 16'd1, 0);
        tick();
        check("t1.mem_read",  32'(Mem_Read), 1);
        check("t1.mem_write", 32'(Mem_Write), 0);
        check("t1.mem_addr",  32'(Mem_Addr), 1);
        check("t1.state_acc", 32'(Dbg_State), 1);
        check("t1.a_ack_early", 32'(A_Ack), 0);
        tick();
        check("t1.a_ack",   32'(A_Ack), 1);
        check("t1.a_rdata", 32'(A_RData), 16'h0002);
        check("t1.a_err",   32'(A_Err), 0);
        check("t1.b_ack",   32'(B_Ack), 0);
        check("t1.mem_read_off", 32'(Mem_Read), 0);
        check("t1.state_resp", 32'(Dbg_State), 2);
        drive_a(0, 0, 0, 0);
        tick();
        check("t1.a_ack_drop", 32'(A_Ack), 0);
        check("t1.rdata_hold", 32'(A_RData), 16'h0002);
        check("t1.state_idle", 32'(Dbg_State), 0);

        // 2: B writes 0x1234 to word 5, then A reads it back
        drive_b(1, 1, 16'd5, 16'h1234);
        tick();
        check("t2.mem_write", 32'(Mem_Write), 1);
        check("t2.mem_read",  32'(Mem_Read), 0);
        check("t2.mem_addr",  32'(Mem_Addr), 5);
        check("t2.mem_din",   32'(Mem_Data_In), 16'h1234);
        tick();
        check("t2.b_ack",     32'(B_Ack), 1);
        check("t2.b_rdata",   32'(B_RData), 16'h1234);
        check("t2.a_ack",     32'(A_Ack), 0);
        check("t2.mem_write_off", 32'(Mem_Write), 0);
        drive_b(0, 0, 0, 0);
        drive_a(1, 0, 16'd5, 0);
        tick();
        check("t2.b_ack_drop", 32'(B_Ack), 0);
        check("t2.no_early_grant", 32'(Mem_Read), 0);
        tick();
        check("t2.a_mem_read", 32'(Mem_Read), 1);
        tick();
        check("t2.a_ack",   32'(A_Ack), 1);
        check("t2.a_rdata", 32'(A_RData), 16'h1234);
        drive_a(0, 0, 0, 0);

        // 3: fresh reset, both request together; grants alternate A,B,A,B
        Rst = 1'b1;
        #1;
        check("t3.async_clr_ack",   32'(A_Ack), 0);
        check("t3.async_clr_rdata", 32'(A_RData), 0);
        tick();
        Rst = 1'b0;
        drive_a(1, 0, 16'd1, 0);
        drive_b(1, 0, 16'd3, 0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            check($sformatf("t3.a_ack_c%0d", k), 32'(A_Ack), 32'((k % 6) == 2));
            check($sformatf("t3.b_ack_c%0d", k), 32'(B_Ack), 32'((k % 6) == 5));
            if (k == 1) check("t3.first_addr", 32'(Mem_Addr), 1);
            if (k == 4) check("t3.second_addr", 32'(Mem_Addr), 3);
            if (k == 2) check("t3.a_rdata", 32'(A_RData), 16'h0002);
            if (k == 5) check("t3.b_rdata", 32'(B_RData), 16'h00AA);
        end
        drive_a(0, 0, 0, 0);
        drive_b(0, 0, 0, 0);

        // 4: A reads out-of-range word 64
        drive_a(1, 0, 16'd64, 0);
        tick();
        check("t4.mem_read",  32'(Mem_Read), 0);
        check("t4.mem_write", 32'(Mem_Write), 0);
        check("t4.mem_addr",  32'(Mem_Addr), 64);
        tick();
        check("t4.a_ack",   32'(A_Ack), 1);
        check("t4.a_err",   32'(A_Err), 1);
        check("t4.a_rdata", 32'(A_RData), 0);
        check("t4.mem_read_resp", 32'(Mem_Read), 0);
        drive_a(0, 0, 0, 0);
        tick();
        check("t4.a_err_drop", 32'(A_Err), 0);

        // 5: B write to word 3 aborted by reset before the negedge
        drive_b(1, 1, 16'd3, 16'hBEEF);
        tick();
        check("t5.mem_write", 32'(Mem_Write), 1);
        Rst = 1'b1;
        drive_b(0, 0, 0, 0);
        #1;
        check_all_zero("t5.abort");
        tick();
        check("t5.no_b_ack", 32'(B_Ack), 0);
        tick();
        Rst = 1'b0;
        drive_a(1, 0, 16'd3, 0);
        tick();
        tick();
        check("t5.a_ack",   32'(A_Ack), 1);
        check("t5.old_val", 32'(A_RData), 16'h00AA);
        drive_a(0, 0, 0, 0);
        tick();

        // 6: A holds Req for four back-to-back accesses
        a_pulses = 0;
        drive_a(1, 0, 16'd1, 0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            check($sformatf("t6.a_ack_c%0d", k), 32'(A_Ack), 32'((k % 3) == 2));
            check($sformatf("t6.b_ack_c%0d", k), 32'(B_Ack), 0);
            if (A_Ack) a_pulses++;
        end
        drive_a(0, 0, 0, 0);
        check("t6.pulse_count", 32'(a_pulses), 4);
        tick();
        tick();
        check("t6.no_extra_ack", 32'(A_Ack), 0);

        // 7: Req dropped right after sampling still completes
        drive_a(1, 0, 16'd5, 0);
        tick();
        drive_a(0, 0, 0, 0);
        tick();
        check("t7.a_ack",   32'(A_Ack), 1);
        check("t7.a_rdata", 32'(A_RData), 16'h1234);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
